// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: sequences a wide add (N_WORDS slices of n_bit bits)
// through an external combinational n_bit-bit ripple-carry adder, one slice
// per clock, carrying between cycles and presenting the assembled result
// through a valid/ready handshake.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   When defined, an extra 'sub' input selects op_a - op_b (B inverted,
//   carry-in forced to 1). When undefined only addition is available.
module nibble_serial_adder #(
  parameter int n_bit   = 4,
  parameter int N_WORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_WORDS*n_bit-1:0]   op_a,
  input  logic [N_WORDS*n_bit-1:0]   op_b,
  input  logic                       cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic                       sub,
`endif
  output logic [n_bit-1:0]           add_a,
  output logic [n_bit-1:0]           add_b,
  output logic                       add_cin,
  input  logic [n_bit-1:0]           add_sum,
  input  logic                       add_cout,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [N_WORDS*n_bit-1:0]   result,
  output logic                       res_cout,
  output logic                       res_ovf
);

  localparam int W  = N_WORDS * n_bit;
  // The slice counter needs at least one bit even for a single-slice build.
  localparam int KW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(N_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    sa_q, sa_d;
  logic [W-1:0]    sb_q, sb_d;
  logic [W-1:0]    res_q, res_d;
  logic            carry_q, carry_d;
  logic [KW-1:0]   k_q, k_d;
  logic            res_cout_q, res_cout_d;
  logic            res_ovf_q, res_ovf_d;

  // State and datapath registers; reset discards any partially built result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sa_q       <= '0;
      sb_q       <= '0;
      res_q      <= '0;
      carry_q    <= 1'b0;
      k_q        <= '0;
      res_cout_q <= 1'b0;
      res_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      res_q      <= res_d;
      carry_q    <= carry_d;
      k_q        <= k_d;
      res_cout_q <= res_cout_d;
      res_ovf_q  <= res_ovf_d;
    end
  end

  // Next-state, datapath update and adder drive; adder inputs are zero
  // whenever no slice is being summed.
  always_comb begin
    state_d    = state_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    res_d      = res_q;
    carry_d    = carry_q;
    k_d        = k_q;
    res_cout_d = res_cout_q;
    res_ovf_d  = res_ovf_q;
    in_ready   = 1'b0;
    res_valid  = 1'b0;
    add_a      = '0;
    add_b      = '0;
    add_cin    = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sa_d    = op_a;
          sb_d    = op_b;
          carry_d = cin;
`ifdef SERIAL_ADDER_SUB_EN
          // Subtraction as A + ~B + 1; the caller's cin is ignored here.
          if (sub) begin
            sb_d    = ~op_b;
            carry_d = 1'b1;
          end
`endif
          k_d     = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        add_a   = sa_q[n_bit-1:0];
        add_b   = sb_q[n_bit-1:0];
        add_cin = carry_q;
        sa_d    = sa_q >> n_bit;
        sb_d    = sb_q >> n_bit;
        // Each new slice enters at the top, so after N_WORDS shifts slice 0
        // sits at the bottom of the result.
        res_d   = res_q >> n_bit;
        res_d[W-1 -: n_bit] = add_sum;
        carry_d = add_cout;
        if (k_q == LAST_K) begin
          // Carry into the MSB is recovered from the MSB sum bit and inputs.
          res_cout_d = add_cout;
          res_ovf_d  = add_cout ^ (sa_q[n_bit-1] ^ sb_q[n_bit-1] ^ add_sum[n_bit-1]);
          state_d    = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end

      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign result   = res_q;
  assign res_cout = res_cout_q;
  assign res_ovf  = res_ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: self-checking bench for nibble_serial_adder.
// Models the external ripple-carry adder slice and checks results against a
// plain-arithmetic reference. Subtraction cases compile only when
// SERIAL_ADDER_SUB_EN is defined.
module tb_nibble_serial_adder;

  localparam int NB = 4;
  localparam int NW = 4;
  localparam int W  = NB * NW;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic          sub;
`endif
  logic [NB-1:0] add_a;
  logic [NB-1:0] add_b;
  logic          add_cin;
  logic [NB-1:0] add_sum;
  logic          add_cout;
  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  result;
  logic          res_cout;
  logic          res_ovf;

  int errors;
  int checks;
  logic cinTrace [NW];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] expRes;
    logic         expCout;
    logic         expOvf;
  } vector_t;

  typedef struct {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
  } refOut_t;

  nibble_serial_adder #(.n_bit(NB), .N_WORDS(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .res_cout  (res_cout),
    .res_ovf   (res_ovf)
  );

  // External combinational adder slice seen by the sequencer.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{NB{1'b0}}, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Whole-word reference: A + B + cin (or A - B), with signed overflow.
  function automatic refOut_t refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c, input logic isSub);
    refOut_t      r;
    logic [W-1:0] effB;
    logic         effC;
    logic [W:0]   s;
    effB   = isSub ? ~b : b;
    effC   = isSub ? 1'b1 : c;
    s      = {1'b0, a} + {1'b0, effB} + {{W{1'b0}}, effC};
    r.res  = s[W-1:0];
    r.cout = s[W];
    r.ovf  = (a[W-1] == effB[W-1]) && (r.res[W-1] != a[W-1]);
    return r;
  endfunction

  // Carry that must enter slice j: carry out of the low j*NB bits.
  function automatic logic refCarryIn(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic c, input logic isSub, input int j);
    logic [W-1:0] effB;
    logic         effC;
    logic [W:0]   mask;
    logic [W:0]   s;
    effB = isSub ? ~b : b;
    effC = isSub ? 1'b1 : c;
    if (j == 0) return effC;
    mask = (({{W{1'b0}}, 1'b1}) << (NB * j)) - 1;
    s    = ({1'b0, a} & mask) + ({1'b0, effB} & mask) + {{W{1'b0}}, effC};
    return s[NB * j];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  // Full operation: accept, per-slice adder drive, latency, result, release.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                               input logic isSub, input logic [W-1:0] expRes,
                               input logic expCout, input logic expOvf, input string tag);
    int edges;
    logic [W-1:0] effB;
    effB = isSub ? ~b : b;
    waitIdle(tag);
    op_a     = a;
    op_b     = b;
    cin      = c;
`ifdef SERIAL_ADDER_SUB_EN
    sub      = isSub;
`endif
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op_a     = W'($urandom);
    op_b     = W'($urandom);
    cin      = 1'($urandom);
    edges    = 0;
    while (!res_valid && edges < 20) begin
      if (edges < NW) begin
        checkOutput({tag, ".add_a"}, {28'd0, add_a}, {28'd0, a[edges*NB +: NB]});
        checkOutput({tag, ".add_b"}, {28'd0, add_b}, {28'd0, effB[edges*NB +: NB]});
        checkOutput({tag, ".add_cin"}, {31'd0, add_cin},
                    {31'd0, refCarryIn(a, b, c, isSub, edges)});
        cinTrace[edges] = add_cin;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    checkOutput({tag, ".latency"}, edges, NW);
    checkOutput({tag, ".result"}, {16'd0, result}, {16'd0, expRes});
    checkOutput({tag, ".res_cout"}, {31'd0, res_cout}, {31'd0, expCout});
    checkOutput({tag, ".res_ovf"}, {31'd0, res_ovf}, {31'd0, expOvf});
    checkOutput({tag, ".add_a_done"}, {28'd0, add_a}, 32'd0);
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    checkOutput({tag, ".back_idle"}, {30'd0, in_ready, res_valid}, 32'd2);
  endtask

  initial begin
    vector_t vecs [6];
    refOut_t r;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic c;
    int n;

    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    cin       = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub       = 1'b0;
`endif
    res_ready = 1'b0;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};

    // Reset state
    #12;
    checkOutput("rst.in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst.res_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("rst.result", {16'd0, result}, 32'd0);
    checkOutput("rst.flags", {30'd0, res_cout, res_ovf}, 32'd0);
    checkOutput("rst.adder", {27'd0, add_a, add_cin}, 32'd0);
    checkOutput("rst.add_b", {28'd0, add_b}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Table vectors
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].c, 1'b0, vecs[i].expRes,
                    vecs[i].expCout, vecs[i].expOvf, $sformatf("vec%0d", i));
      if (i == 1) begin
        checkOutput("ripple.trace", {28'd0, cinTrace[0], cinTrace[1], cinTrace[2], cinTrace[3]},
                    32'b0111);
      end
    end

    // Backpressure with ignored operand pulses
    waitIdle("bp");
    op_a = 16'h1234; op_b = 16'h4321; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp.valid", {31'd0, res_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i >= 2 && i <= 5);
      op_a = W'($urandom);
      op_b = W'($urandom);
      @(posedge clk);
      @(negedge clk);
      checkOutput("bp.hold", {13'd0, res_valid, in_ready, res_cout, res_ovf, result},
                  {13'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h5555});
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    checkOutput("bp.release", {30'd0, in_ready, res_valid}, 32'd2);
    repeat (6) @(negedge clk);
    checkOutput("bp.no_reaccept", {30'd0, in_ready, res_valid}, 32'd2);

    // Asynchronous reset during RUN cycle 2
    waitIdle("arst");
    op_a = 16'hABCD; op_b = 16'h1111; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("arst.running", {31'd0, in_ready}, 32'd0);
    #1 rst = 1'b1;
    #1;
    checkOutput("arst.in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("arst.result", {16'd0, result}, 32'd0);
    checkOutput("arst.outs", {25'd0, res_valid, res_cout, res_ovf, add_a}, 32'd0);
    checkOutput("arst.adder_b", {27'd0, add_b, add_cin}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, "post_rst");

`ifdef SERIAL_ADDER_SUB_EN
    applyStimulus(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub0");
    applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub1");
`endif

    // Randomized operations against the reference model
    for (int i = 0; i < 25; i++) begin
      logic isSub;
      a = W'($urandom);
      b = W'($urandom);
      c = 1'($urandom);
      isSub = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      isSub = 1'($urandom);
`endif
      if (i % 5 == 0) b = ~a;
      r = refModel(a, b, c, isSub);
      applyStimulus(a, b, c, isSub, r.res, r.cout, r.ovf, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
